// File: rtl/req_capture_fifo.sv
// Captures a quasi-static request word a fixed settle time after each request
// pulse and queues it in a small FIFO for a valid/ready consumer.
module req_capture_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clkB,
    input  logic                     resetB,
    input  logic                     req_pulse,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     cmd_valid,
    output logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf_err,
    output logic                     drop_err,
    input  logic                     err_clr,
    output logic [15:0]              accept_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] SETTLE_LD =
        (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;
    logic [15:0]       acc_q, acc_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic full;
    logic pop;
    logic push;
    logic ovf_ev;
    logic drop_ev;

    assign full = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop  = valid_q && cmd_ready;

    always_ff @(posedge clkB or negedge resetB) begin
        if (!resetB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_pulse) begin
                    if (SETTLE_CYC == 0) begin
                        state_d = WRITE;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LD;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = WRITE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts the word when the head leaves on the same edge.
    always_comb begin
        push    = (state_q == WRITE) && (!full || pop);
        ovf_ev  = (state_q == WRITE) && full && !pop;
        drop_ev = req_pulse && (state_q != IDLE);
        wptr_d  = wptr_q + (AW+1)'(push);
        rptr_d  = rptr_q + (AW+1)'(pop);
        valid_d = (wptr_d != rptr_d);
        ovf_d   = ovf_ev  || (ovf_q  && !err_clr);
        drop_d  = drop_ev || (drop_q && !err_clr);
        acc_d   = acc_q + 16'(push);
    end

    always_ff @(posedge clkB) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= req_data;
    end

    assign cmd_valid  = valid_q;
    assign cmd_data   = valid_q ? mem_q[rptr_q[AW-1:0]] : '0;
    assign fifo_level = wptr_q - rptr_q;
    assign ovf_err    = ovf_q;
    assign drop_err   = drop_q;
    assign accept_cnt = acc_q;

endmodule

// File: tb/tb_req_capture_fifo.sv
// Bench for req_capture_fifo: vector table, corner sequences and random
// traffic against a queue-based reference model.
module tb_req_capture_fifo;

    localparam int S = 2;
    localparam int D = 4;

    logic        clkB = 1'b0;
    logic        resetB = 1'b0;
    logic        req_pulse = 1'b0;
    logic [31:0] req_data = '0;
    logic        cmd_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic [2:0]  fifo_level;
    logic        ovf_err;
    logic        drop_err;
    logic [15:0] accept_cnt;

    logic        z_pulse = 1'b0;
    logic [31:0] z_data = '0;
    logic        z_ready = 1'b0;
    logic        z_valid;
    logic [31:0] z_cdata;
    logic [2:0]  z_level;
    logic        z_ovf;
    logic        z_drop;
    logic [15:0] z_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    bit          m_busy;
    int          m_wr_at;
    int          cyc;
    bit          m_ovf;
    bit          m_drop;
    logic [15:0] m_cnt;
    logic [31:0] zgot[$];
    logic [31:0] zsent[$];

    always #5 clkB = ~clkB;

    req_capture_fifo #(.DATA_W(32), .DEPTH(D), .SETTLE_CYC(S)) u_dut (
        .clkB(clkB), .resetB(resetB),
        .req_pulse(req_pulse), .req_data(req_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .fifo_level(fifo_level),
        .ovf_err(ovf_err), .drop_err(drop_err),
        .err_clr(err_clr), .accept_cnt(accept_cnt)
    );

    req_capture_fifo #(.DATA_W(32), .DEPTH(D), .SETTLE_CYC(0)) u_zero (
        .clkB(clkB), .resetB(resetB),
        .req_pulse(z_pulse), .req_data(z_data),
        .cmd_valid(z_valid), .cmd_data(z_cdata),
        .cmd_ready(z_ready), .fifo_level(z_level),
        .ovf_err(z_ovf), .drop_err(z_drop),
        .err_clr(1'b0), .accept_cnt(z_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 0;
        m_ovf  = 0;
        m_drop = 0;
        m_cnt  = '0;
    endtask

    // One capture in flight: write lands S+1 edges after the starting pulse.
    task automatic model_edge();
        bit pop_m, full_m, drop_ev, wr, ovf_ev;
        pop_m   = (mq.size() > 0) && cmd_ready;
        full_m  = (mq.size() == D);
        drop_ev = req_pulse && m_busy;
        wr      = 0;
        ovf_ev  = 0;
        if (m_busy && cyc == m_wr_at) begin
            wr = 1;
            m_busy = 0;
        end else if (!m_busy && req_pulse) begin
            m_busy = 1;
            m_wr_at = cyc + S + 1;
        end
        if (pop_m) void'(mq.pop_front());
        if (wr) begin
            if (!full_m || pop_m) begin
                mq.push_back(req_data);
                m_cnt = m_cnt + 16'd1;
            end else begin
                ovf_ev = 1;
            end
        end
        m_ovf  = ovf_ev  || (m_ovf  && !err_clr);
        m_drop = drop_ev || (m_drop && !err_clr);
    endtask

    task automatic check_all();
        chk("valid", cmd_valid, mq.size() > 0);
        chk("level", fifo_level, mq.size());
        chk("ovf", ovf_err, m_ovf);
        chk("drop", drop_err, m_drop);
        chk("acc", accept_cnt, m_cnt);
        if (mq.size() > 0) chk("data", cmd_data, mq[0]);
    endtask

    task automatic tick();
        @(posedge clkB);
        if (resetB) model_edge();
        cyc++;
        #1;
        check_all();
        if (z_valid) zgot.push_back(z_cdata);
    endtask

    task automatic do_reset();
        resetB = 1'b0;
        #1;
        model_clear();
        tick();
        tick();
        resetB = 1'b1;
    endtask

    task automatic capture(input logic [31:0] w);
        req_data  = w;
        req_pulse = 1'b1;
        tick();
        req_pulse = 1'b0;
        repeat (5) tick();
    endtask

    typedef struct {
        logic        p;
        logic [31:0] d;
        logic        r;
        logic        c;
        logic        ev;
        logic [31:0] ed;
        int          el;
        logic        eo;
        logic        edr;
        int          ec;
    } vec_t;

    vec_t tv[10];

    initial begin
        cyc = 0;
        model_clear();
        tv[0] = '{1'b1, 32'hA5A50001, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 0};
        tv[1] = '{1'b0, 32'hA5A50001, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 0};
        tv[2] = '{1'b0, 32'hA5A50001, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 0};
        tv[3] = '{1'b0, 32'hA5A50001, 1'b1, 1'b0, 1'b1, 32'hA5A50001, 1, 1'b0, 1'b0, 1};
        tv[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1};
        tv[5] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1};
        tv[6] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1};
        tv[7] = '{1'b0, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1};
        tv[8] = '{1'b0, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 1, 1'b0, 1'b1, 2};
        tv[9] = '{1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 2};

        #1;
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_data", cmd_data, 32'h0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_acc", accept_cnt, 16'd0);
        do_reset();
        repeat (7) tick();

        for (int i = 0; i < 10; i++) begin
            req_pulse = tv[i].p;
            req_data  = tv[i].d;
            cmd_ready = tv[i].r;
            err_clr   = tv[i].c;
            tick();
            chk($sformatf("tv%0d_valid", i), cmd_valid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("tv%0d_data", i), cmd_data, tv[i].ed);
            chk($sformatf("tv%0d_level", i), fifo_level, tv[i].el);
            chk($sformatf("tv%0d_ovf", i), ovf_err, tv[i].eo);
            chk($sformatf("tv%0d_drop", i), drop_err, tv[i].edr);
            chk($sformatf("tv%0d_acc", i), accept_cnt, tv[i].ec);
        end
        req_pulse = 1'b0;
        err_clr = 1'b0;
        cmd_ready = 1'b0;

        do_reset();
        for (int k = 1; k <= 5; k++) capture(32'h1000_0000 + k);
        chk("full_level", fifo_level, 3'd4);
        chk("full_ovf", ovf_err, 1'b1);
        chk("full_acc", accept_cnt, 16'd4);
        chk("full_head", cmd_data, 32'h1000_0001);

        do_reset();
        for (int k = 1; k <= 4; k++) capture(32'h2000_0000 + k);
        req_data = 32'h2000_0005;
        req_pulse = 1'b1;
        tick();
        req_pulse = 1'b0;
        tick();
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("fullpop_level", fifo_level, 3'd4);
        chk("fullpop_ovf", ovf_err, 1'b0);
        chk("fullpop_acc", accept_cnt, 16'd5);
        chk("fullpop_head", cmd_data, 32'h2000_0002);

        do_reset();
        req_data = 32'hCAFE_0001;
        req_pulse = 1'b1;
        tick();
        req_pulse = 1'b0;
        tick();
        #2;
        resetB = 1'b0;
        #1;
        chk("abort_valid", cmd_valid, 1'b0);
        chk("abort_level", fifo_level, 3'd0);
        chk("abort_acc", accept_cnt, 16'd0);
        chk("abort_data", cmd_data, 32'h0);
        model_clear();
        tick();
        tick();
        resetB = 1'b1;
        repeat (4) tick();
        chk("abort_nowrite", accept_cnt, 16'd0);
        req_data = 32'hCAFE_0002;
        req_pulse = 1'b1;
        tick();
        req_pulse = 1'b0;
        tick();
        tick();
        chk("relat_early", cmd_valid, 1'b0);
        tick();
        chk("relat_valid", cmd_valid, 1'b1);
        chk("relat_data", cmd_data, 32'hCAFE_0002);
        chk("relat_acc", accept_cnt, 16'd1);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_pulse = ($urandom_range(0, 3) == 0);
            if (req_pulse && !m_busy) req_data = $urandom;
            cmd_ready = (i < 200) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_pulse = 1'b0;
        err_clr = 1'b0;
        cmd_ready = 1'b0;

        do_reset();
        z_ready = 1'b1;
        zgot.delete();
        zsent.delete();
        for (int i = 0; i < 2*D + 3; i++) begin
            z_data = 32'h5A00_0000 + i;
            zsent.push_back(z_data);
            z_pulse = 1'b1;
            tick();
            z_pulse = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk("wrap_count", zgot.size(), zsent.size());
        for (int i = 0; i < zsent.size(); i++) begin
            if (i < zgot.size()) chk($sformatf("wrap_w%0d", i), zgot[i], zsent[i]);
        end
        chk("wrap_acc", z_cnt, 16'd11);
        chk("wrap_ovf", z_ovf, 1'b0);
        chk("wrap_drop", z_drop, 1'b0);
        chk("wrap_level", z_level, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/req_capture_fifo.md
REQ_CAPTURE_FIFO -- requirements
Module: req_capture_fifo

Interface
REQ-001 Parameter DATA_W, default 32: width of the captured request word.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-003 Parameter SETTLE_CYC, default 2, range 0-15: clkB cycles to wait after a request pulse before sampling req_data.
REQ-004 clkB  input  1  destination-domain clock; all logic is rising-edge on clkB.
REQ-005 resetB  input  1  asynchronous, active-low reset.
REQ-006 req_pulse  input  1  single-cycle request pulse from the level/ack synchronizer output in the clkB domain.
REQ-007 req_data  input  DATA_W  quasi-static bus from the clkA domain; held stable while the synchronized request level is high.
REQ-008 cmd_valid  output  1  FIFO head is valid.
REQ-009 cmd_data  output  DATA_W  FIFO head word.
REQ-010 cmd_ready  input  1  consumer accepts the head when cmd_valid is also high.
REQ-011 fifo_level  output  clog2(DEPTH)+1  current occupancy.
REQ-012 ovf_err  output  1  sticky flag: a capture was lost because the FIFO was full.
REQ-013 drop_err  output  1  sticky flag: a req_pulse arrived while a capture was in progress.
REQ-014 err_clr  input  1  single-cycle clear for ovf_err and drop_err.
REQ-015 accept_cnt  output  16  count of words written to the FIFO; wraps from 0xFFFF to 0.

Function
REQ-016 The control FSM SHALL have three states: IDLE, SETTLE and WRITE.
REQ-017 IDLE + req_pulse: go to SETTLE and load the settle counter with SETTLE_CYC-1; if SETTLE_CYC=0, go directly to WRITE.
REQ-018 SETTLE: decrement the counter each cycle and go to WRITE on the cycle the counter reads 0.
REQ-019 WRITE: sample req_data into the FIFO tail if a slot is free, then return to IDLE unconditionally. WRITE lasts exactly one cycle.
REQ-020 Latency: pulse at cycle N gives the write edge at N+SETTLE_CYC+1; with an empty FIFO, cmd_valid=1 and cmd_data equal to the sampled word at N+SETTLE_CYC+2.
REQ-021 req_pulse in SETTLE or WRITE: ignore it and set drop_err; the FSM does not restart.
REQ-022 Pop occurs when cmd_valid && cmd_ready; the head advances on that edge.
REQ-023 cmd_data SHALL hold its value while cmd_valid=1 and cmd_ready=0.
REQ-024 WRITE while full with no pop in the same cycle: discard the word, set ovf_err, leave accept_cnt unchanged.
REQ-025 WRITE while full with a pop in the same cycle: accept the word; fifo_level stays at DEPTH; no error.
REQ-026 Simultaneous push and pop at any other occupancy: fifo_level is unchanged.
REQ-027 Read and write pointers SHALL be clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-028 Full = MSBs differ and low bits equal; empty = pointers equal.
REQ-029 cmd_valid SHALL be the registered not-empty condition, with no combinational path from cmd_ready to cmd_valid.
REQ-030 accept_cnt increments by 1 on each successful write.
REQ-031 err_clr clears both sticky flags; if an error event occurs in the same cycle, the set wins.

Reset
REQ-032 resetB low SHALL asynchronously force: FSM=IDLE, settle counter=0, pointers=0, cmd_valid=0, fifo_level=0, ovf_err=0, drop_err=0, accept_cnt=0.
REQ-033 On reset, cmd_data SHALL read 0; FIFO storage need not be reset.
REQ-034 Reset asserted mid-SETTLE or mid-WRITE SHALL abort the capture with no write.
REQ-035 The first req_pulse after reset release SHALL be handled normally.

Verification
REQ-036 SETTLE_CYC=2, req_data=0xA5A5_0001, one pulse at cycle 10, cmd_ready=1 -> write at 13, cmd_valid=1 with cmd_data=0xA5A5_0001 at 14, accept_cnt=1, level back to 0 at 15.
REQ-037 DEPTH=4, cmd_ready=0, five captured pulses spaced 6 cycles apart -> fifo_level=4, ovf_err=1, accept_cnt=4, head still word 1.
REQ-038 FIFO full, fifth WRITE coincident with cmd_ready=1 -> word accepted, fifo_level=4, ovf_err=0, accept_cnt=5.
REQ-039 Second pulse 1 cycle after the first (SETTLE_CYC=2) -> drop_err=1, exactly one word written; err_clr pulse -> drop_err=0 next cycle.
REQ-040 resetB low during SETTLE -> all outputs at reset values, no word written; next pulse after release captured with normal latency.
REQ-041 SETTLE_CYC=0 with 2*DEPTH+3 pulses and continuous pop -> every word delivered in order (pointer wrap), no errors, accept_cnt=11.
